// File: rtl/csram_stream_loader_if.sv
// Stream-in / RAM-out / status bundle of the CSRAM stream loader.
// The loader uses the slave view; the stream source and RAM side use the master view.
interface csram_stream_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_di;
  logic                  busy;
  logic                  load_done;
  logic                  load_err;
  logic [1:0]            err_code;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, ram_en, ram_we, ram_addr, ram_di,
    output busy, load_done, load_err, err_code
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, ram_en, ram_we, ram_addr, ram_di,
    input  busy, load_done, load_err, err_code
  );
endinterface

// File: rtl/csram_stream_loader.sv
// Loads a framed word stream (header, N payload words, XOR checksum) into the
// CSRAM narrow write port and reports a clean load or the cause of a failure.
module csram_stream_loader #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 12,
  parameter int         DEPTH      = 4096,
  parameter logic [7:0] MAGIC      = 8'hC5
) (
  input logic                 clk,
  input logic                 rst_n,
  csram_stream_loader_if.slave bus
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         DEPTH_W  = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t                state_r;
  logic                  s_ready_r;
  logic                  ram_en_r;
  logic                  ram_we_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_di_r;
  logic                  busy_r;
  logic                  load_done_r;
  logic                  load_err_r;
  logic [1:0]            err_code_r;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [CW-1:0]         rem_r;
  logic [DATA_WIDTH-1:0] chk_r;
  logic                  err_last_r;
  logic                  accept_s;

  function automatic logic [ADDR_WIDTH-1:0] hdr_start(input logic [DATA_WIDTH-1:0] hdr);
    return hdr[2*ADDR_WIDTH-1:ADDR_WIDTH];
  endfunction

  function automatic logic [CW-1:0] hdr_count(input logic [DATA_WIDTH-1:0] hdr);
    return {1'b0, hdr[ADDR_WIDTH-1:0]} + CNT_ONE;
  endfunction

  // Start+count is formed one bit wider than the address so S+N = DEPTH stays legal.
  function automatic logic hdr_legal(input logic [DATA_WIDTH-1:0] hdr);
    logic [CW-1:0] end_w;
    end_w = {1'b0, hdr_start(hdr)} + hdr_count(hdr);
    return (hdr[DATA_WIDTH-1 -: 8] == MAGIC) && (end_w <= DEPTH_W);
  endfunction

  assign accept_s      = bus.s_valid & s_ready_r;
  assign bus.s_ready   = s_ready_r;
  assign bus.ram_en    = ram_en_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_di    = ram_di_r;
  assign bus.busy      = busy_r;
  assign bus.load_done = load_done_r;
  assign bus.load_err  = load_err_r;
  assign bus.err_code  = err_code_r;

  // Frame FSM with registered write port, handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      s_ready_r   <= 1'b1;
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_di_r    <= '0;
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
      err_code_r  <= 2'd0;
      cnt_r       <= '0;
      rem_r       <= '0;
      chk_r       <= '0;
      err_last_r  <= 1'b0;
    end else begin
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            busy_r     <= 1'b1;
            err_last_r <= bus.s_last;
            if (!hdr_legal(bus.s_data)) begin
              state_r    <= ERR;
              err_code_r <= 2'd1;
              load_err_r <= 1'b1;
            end else if (bus.s_last) begin
              state_r    <= ERR;
              err_code_r <= 2'd2;
              load_err_r <= 1'b1;
            end else begin
              state_r    <= LOAD;
              err_code_r <= 2'd0;
              cnt_r      <= hdr_start(bus.s_data);
              rem_r      <= hdr_count(bus.s_data);
              chk_r      <= bus.s_data;
            end
          end
        end
        LOAD: begin
          if (accept_s) begin
            if (bus.s_last) begin
              state_r    <= ERR;
              err_code_r <= 2'd2;
              load_err_r <= 1'b1;
              err_last_r <= 1'b1;
            end else begin
              ram_en_r   <= 1'b1;
              ram_we_r   <= 1'b1;
              ram_addr_r <= cnt_r;
              ram_di_r   <= bus.s_data;
              chk_r      <= chk_r ^ bus.s_data;
              cnt_r      <= cnt_r + ADDR_ONE;
              rem_r      <= rem_r - CNT_ONE;
              if (rem_r == CNT_ONE) begin
                state_r <= CHECK;
              end
            end
          end
        end
        CHECK: begin
          if (accept_s) begin
            if (!bus.s_last) begin
              state_r    <= ERR;
              err_code_r <= 2'd2;
              load_err_r <= 1'b1;
              err_last_r <= 1'b0;
            end else if (bus.s_data != chk_r) begin
              state_r    <= ERR;
              err_code_r <= 2'd3;
              load_err_r <= 1'b1;
              err_last_r <= 1'b1;
            end else begin
              state_r     <= DONE;
              s_ready_r   <= 1'b0;
              busy_r      <= 1'b0;
              load_done_r <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r   <= IDLE;
          s_ready_r <= 1'b1;
        end
        ERR: begin
          // Drain the rest of the frame unless the failing word already closed it.
          if (err_last_r || (accept_s && bus.s_last)) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            err_last_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          s_ready_r <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule
